// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources.
// Optional BUSY watchdog is compiled in with `define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic                     I_CLK,
    input  logic                     I_RSTF,
    input  logic [N_REQ-1:0]         I_REQ,
    input  logic [8*N_REQ-1:0]       I_DATA,
    output logic [N_REQ-1:0]         O_ACK,
    output logic                     O_TX_START,
    output logic [7:0]               O_TX_DATA,
    input  logic                     I_TX_DONE,
    output logic [$clog2(N_REQ)-1:0] O_GNT_ID,
    output logic                     O_BUSY,
    output logic                     O_TIMEOUT
);

    localparam int unsigned GW = $clog2(N_REQ);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e             r_state,   w_state_nxt;
    logic [GW-1:0]      r_ptr,     w_ptr_nxt;
    logic [GW-1:0]      r_gnt,     w_gnt_nxt;
    logic [7:0]         r_data,    w_data_nxt;
    logic [N_REQ-1:0]   r_ack,     w_ack_nxt;
    logic               r_start,   w_start_nxt;
    logic               r_busy,    w_busy_nxt;

    logic               w_any;
    logic [GW-1:0]      w_win;
    logic [GW-1:0]      w_idx;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]      r_cnt,     w_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;
`endif

    // First set request after r_ptr, wrapping, with r_ptr itself scanned last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = GW'((32'(r_ptr) + k) % N_REQ);
            if (!w_any && I_REQ[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_ack_nxt   = '0;
        w_start_nxt = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_nxt = StBusy;
                    w_ptr_nxt   = w_win;
                    w_gnt_nxt   = w_win;
                    w_data_nxt  = I_DATA[{w_win, 3'b000} +: 8];
                    w_ack_nxt   = N_REQ'(1) << w_win;
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            StBusy: begin
                if (I_TX_DONE) begin
                    w_state_nxt = StIdle;
                    w_busy_nxt  = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    // ptr already points at the hung grant, so the next scan moves on.
                    w_state_nxt   = StIdle;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
`endif
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_state <= StIdle;
            r_ptr   <= GW'(N_REQ - 1);
            r_gnt   <= '0;
            r_data  <= 8'h00;
            r_ack   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_data  <= w_data_nxt;
            r_ack   <= w_ack_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign O_TIMEOUT = r_timeout;
`else
    assign O_TIMEOUT = 1'b0;
`endif

    assign O_ACK      = r_ack;
    assign O_TX_START = r_start;
    assign O_TX_DATA  = r_data;
    assign O_GNT_ID   = r_gnt;
    assign O_BUSY     = r_busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_tx` transmitter among `N_REQ` byte sources, such as a loopback path, a status reporter and a debug dumper. The arbiter sits between the requesters and `uart_tx`. It latches one byte per grant, pulses the transmitter's start, and waits for its done pulse before granting again. Fairness is strict round-robin, and a lone requester can stream back-to-back bytes.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 8192: BUSY cycles before abort. Used only when the timeout feature is compiled in.

Ports, clock and reset first:
- `I_CLK` in 1: system clock (50 MHz).
- `I_RSTF` in 1: reset, asynchronous and active-low.
- `I_REQ` in `N_REQ`: level request per requester. Bit i high means `I_DATA[8i+7:8i]` is valid.
- `I_DATA` in `8*N_REQ`: flattened bytes; requester i owns bits `[8i+7:8i]`.
- `O_ACK` out `N_REQ`: one-cycle pulse when requester i's byte is captured.
- `O_TX_START` out 1: one-cycle start pulse to `uart_tx`.
- `O_TX_DATA` out 8: registered byte to `uart_tx`. Held stable through BUSY.
- `I_TX_DONE` in 1: one-cycle done pulse from `uart_tx`.
- `O_GNT_ID` out `clog2(N_REQ)`: index of the current or last granted requester.
- `O_BUSY` out 1: high while a byte is in flight.
- `O_TIMEOUT` out 1: one-cycle pulse on watchdog abort. Constant 0 when the feature is compiled out.

## Operation
- FSM has two states, IDLE and BUSY. Reset state is IDLE.
- IDLE, with no `I_REQ` bit set: the arbiter stays in IDLE and drives all pulses low.
- IDLE, with any `I_REQ` bit set, the winner `w` is the first set bit scanning `ptr+1, ptr+2, … ptr` modulo `N_REQ`. On the clock edge, the arbiter:
  - registers `O_TX_DATA` with byte `w`;
  - sets `O_GNT_ID` to `w`;
  - sets `ptr` to `w`;
  - sets `O_ACK[w]` and `O_TX_START` for one cycle;
  - enters BUSY.
- After `O_ACK[w]`, requester `w` may change its data or drop its request. If it keeps `I_REQ[w]` high, that is a new, independent request.
- BUSY: `I_REQ` is ignored. On `I_TX_DONE`, the arbiter returns to IDLE; `O_TX_DATA` and `O_GNT_ID` hold their values.
- `I_TX_DONE` in IDLE is ignored and causes no state change.
- `ptr` resets to `N_REQ-1`, so requester 0 has top priority on the first grant.
- At most one `O_ACK` bit is high in any cycle. `O_ACK` and `O_TX_START` are always coincident.
- Reset asserted mid-byte returns the FSM to IDLE at once and clears all outputs. The caller must also reset `uart_tx`; the shared `I_RSTF` does this.
- Reset values of outputs: `O_ACK`=0, `O_TX_START`=0, `O_TX_DATA`=8'h00, `O_GNT_ID`=0, `O_BUSY`=0, `O_TIMEOUT`=0.

## Timing
- Request-to-start latency: `I_REQ` sampled high in IDLE at edge n gives `O_TX_START` and `O_ACK` high during cycle n+1.
- `O_BUSY` rises together with `O_TX_START`. It falls on the edge after the cycle in which `I_TX_DONE` is high.
- Back-to-back gap: `I_TX_DONE` in cycle k, then the next `O_TX_START` in cycle k+2 at the earliest (one IDLE cycle).
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `UART_TX_ARBITER_TIMEOUT_EN`.
- Defined:
  - A counter of width `clog2(TIMEOUT_CYCLES+1)` clears on entering BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES` without `I_TX_DONE`, the FSM goes to IDLE and `O_TIMEOUT` pulses for one cycle.
  - `ptr` still advances, so a hung transmitter cannot lock out other requesters.
  - `I_TX_DONE` arriving in the same cycle as the terminal count wins: normal completion, no timeout pulse.
- Undefined: no counter is built, `O_TIMEOUT` is tied to 0, and BUSY waits indefinitely for `I_TX_DONE`.

## Test plan
- Reset, then `I_REQ`=4'b0001 with byte0=8'hA5 → `O_TX_START` and `O_ACK`=4'b0001 in cycle 1, `O_TX_DATA`=8'hA5, `O_GNT_ID`=0. Done returns the FSM to IDLE; since req0 is still high, a second start follows 2 cycles after done.
- `I_REQ`=4'b1111 held, with bytes 8'h10/8'h11/8'h12/8'h13 → grant order 0,1,2,3,0. Each start follows the previous done by exactly 2 cycles.
- `ptr`=1 (last grant was 1) with `I_REQ`=4'b0011 → grant 0 next, not 1. Then request 1 gets the following grant.
- `I_TX_DONE` pulsed while IDLE, and `I_REQ` toggled during BUSY → no state change and no extra `O_ACK`.
- `I_RSTF` asserted in the middle of BUSY → `O_BUSY`=0 and `O_TX_DATA`=8'h00 at once. After release, `I_REQ`=4'b0100 is granted to requester 2 with no stale done being honoured.
- With `UART_TX_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, withhold `I_TX_DONE` → `O_TIMEOUT` pulses 16 BUSY cycles after start, the FSM returns to IDLE, and the next requester is granted. Without the macro, the FSM stays in BUSY and `O_TIMEOUT` stays 0.
